// File: rtl/w_reg_ctx_ctrl.sv
// W register write controller with a circular LIFO context stack; W updates on the sampling edge (registered, no bypass).
// Build macro W_ZERO_FLAG_EN adds a registered w_zero flag that tracks the value shown on w_out.
module w_reg_ctx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CTX_DEPTH  = 4,
  parameter int CTX_PTR_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_stb,
  input  logic [2:0]            wr_op,
  input  logic                  dest_f,
  input  logic [DATA_WIDTH-1:0] alu_in,
  input  logic [DATA_WIDTH-1:0] gpr_in,
  input  logic [DATA_WIDTH-1:0] lit_in,
  input  logic                  ctx_push,
  input  logic                  ctx_pop,
  output logic [DATA_WIDTH-1:0] w_out,
  output logic [CTX_PTR_W:0]    ctx_level,
  output logic                  ctx_ovf,
  output logic                  ctx_unf,
`ifdef W_ZERO_FLAG_EN
  output logic                  w_zero,
`endif
  output logic                  wr_drop
);

  localparam int LVL_W = CTX_PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(CTX_DEPTH);

  localparam logic [2:0] OP_CLR   = 3'd1;
  localparam logic [2:0] OP_ALU_D = 3'd2;
  localparam logic [2:0] OP_GPR_D = 3'd3;
  localparam logic [2:0] OP_LIT   = 3'd4;
  localparam logic [2:0] OP_ALU   = 3'd5;

  logic [DATA_WIDTH-1:0] wReg;
  logic [DATA_WIDTH-1:0] wNext;
  logic [DATA_WIDTH-1:0] wrVal;
  logic [DATA_WIDTH-1:0] ctxMem [CTX_DEPTH];
  logic [CTX_PTR_W-1:0]  wrPtr;
  logic [CTX_PTR_W-1:0]  topPtr;
  logic [LVL_W-1:0]      level;
  logic                  ovfFlag;
  logic                  unfFlag;
  logic                  dropFlag;
  logic                  wrEn;
  logic                  isEmpty;
  logic                  isFull;
  logic                  doPush;
  logic                  doPop;
  logic                  doXchg;
  logic                  popOnly;
  logic                  popEmpty;

  // Decode the write op into an "effective write" (one that actually changes W) and its value.
  always_comb begin
    wrEn  = 1'b0;
    wrVal = '0;
    if (wr_stb) begin
      case (wr_op)
        OP_CLR:   begin wrEn = 1'b1;    wrVal = '0;     end
        OP_ALU_D: begin wrEn = !dest_f; wrVal = alu_in; end
        OP_GPR_D: begin wrEn = !dest_f; wrVal = gpr_in; end
        OP_LIT:   begin wrEn = 1'b1;    wrVal = lit_in; end
        OP_ALU:   begin wrEn = 1'b1;    wrVal = alu_in; end
        default:  begin wrEn = 1'b0;    wrVal = '0;     end
      endcase
    end
  end

  always_comb begin
    topPtr   = wrPtr - CTX_PTR_W'(1);
    isEmpty  = (level == '0);
    isFull   = (level == FULL_LVL);
    doPop    = ctx_pop && !isEmpty;
    popEmpty = ctx_pop && isEmpty;
    doPush   = ctx_push && !ctx_pop;
    doXchg   = doPop && ctx_push;
    popOnly  = doPop && !ctx_push;
    // A restore from the stack wins over any pending write.
    wNext = wReg;
    if (doPop) begin
      wNext = ctxMem[topPtr];
    end else if (wrEn) begin
      wNext = wrVal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wReg     <= '0;
      wrPtr    <= '0;
      level    <= '0;
      ovfFlag  <= 1'b0;
      unfFlag  <= 1'b0;
      dropFlag <= 1'b0;
    end else begin
      wReg     <= wNext;
      dropFlag <= doPop && wrEn;
      if (doPush) begin
        wrPtr <= wrPtr + CTX_PTR_W'(1);
        if (isFull) begin
          ovfFlag <= 1'b1;
        end else begin
          level <= level + LVL_W'(1);
        end
      end else if (popOnly) begin
        wrPtr <= topPtr;
        level <= level - LVL_W'(1);
      end
      if (popEmpty) begin
        unfFlag <= 1'b1;
      end
    end
  end

  // Stack storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (doPush) begin
      ctxMem[wrPtr] <= wReg;
    end else if (doXchg) begin
      ctxMem[topPtr] <= wReg;
    end
  end

`ifdef W_ZERO_FLAG_EN
  logic wZero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wZero <= 1'b1;
    end else begin
      wZero <= (wNext == '0);
    end
  end

  assign w_zero = wZero;
`endif

  assign w_out     = wReg;
  assign ctx_level = level;
  assign ctx_ovf   = ovfFlag;
  assign ctx_unf   = unfFlag;
  assign wr_drop   = dropFlag;

endmodule

// File: tb/tb_w_reg_ctx_ctrl.sv
// Table-driven bench for w_reg_ctx_ctrl: per-cycle vectors feed a scoreboard queue of expected outputs.
module tb_w_reg_ctx_ctrl;

  localparam logic [2:0] NONE = 3'd0, CLR = 3'd1, ALUD = 3'd2, GPRD = 3'd3, LIT = 3'd4, ALU = 3'd5;

  typedef struct {
    logic       stb;
    logic [2:0] op;
    logic       dest;
    logic [7:0] alu;
    logic [7:0] gpr;
    logic [7:0] lit;
    logic       push;
    logic       pop;
    logic [7:0] eW;
    logic [2:0] eLvl;
    logic       eOvf;
    logic       eUnf;
    logic       eDrop;
  } vec_t;

  typedef struct {
    logic [7:0] w;
    logic [2:0] lvl;
    logic       ovf;
    logic       unf;
    logic       drop;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_stb = 1'b0;
  logic [2:0] wr_op = 3'd0;
  logic       dest_f = 1'b0;
  logic [7:0] alu_in = 8'h00;
  logic [7:0] gpr_in = 8'h00;
  logic [7:0] lit_in = 8'h00;
  logic       ctx_push = 1'b0;
  logic       ctx_pop = 1'b0;
  logic [7:0] w_out;
  logic [2:0] ctx_level;
  logic       ctx_ovf;
  logic       ctx_unf;
  logic       wr_drop;
`ifdef W_ZERO_FLAG_EN
  logic       w_zero;
`endif

  int nCmp = 0;
  int nFail = 0;
  vec_t vecs[$];
  exp_t expQ[$];

  w_reg_ctx_ctrl #(.DATA_WIDTH(8), .CTX_DEPTH(4), .CTX_PTR_W(2)) dut (
    .clk(clk), .rst(rst), .wr_stb(wr_stb), .wr_op(wr_op), .dest_f(dest_f),
    .alu_in(alu_in), .gpr_in(gpr_in), .lit_in(lit_in),
    .ctx_push(ctx_push), .ctx_pop(ctx_pop), .w_out(w_out), .ctx_level(ctx_level),
    .ctx_ovf(ctx_ovf), .ctx_unf(ctx_unf),
`ifdef W_ZERO_FLAG_EN
    .w_zero(w_zero),
`endif
    .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic stb, logic [2:0] op, logic dest, logic [7:0] alu, logic [7:0] gpr,
                              logic [7:0] lit, logic push, logic pop, logic [7:0] eW, logic [2:0] eLvl,
                              logic eOvf, logic eUnf, logic eDrop);
    vec_t v;
    v.stb = stb; v.op = op; v.dest = dest; v.alu = alu; v.gpr = gpr; v.lit = lit;
    v.push = push; v.pop = pop; v.eW = eW; v.eLvl = eLvl; v.eOvf = eOvf; v.eUnf = eUnf; v.eDrop = eDrop;
    return v;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] req);
    nCmp++;
    if (act !== req) begin
      nFail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic checkNow(string tag, exp_t e);
    chk({tag, " w_out"}, w_out, e.w);
    chk({tag, " ctx_level"}, {5'd0, ctx_level}, {5'd0, e.lvl});
    chk({tag, " ctx_ovf"}, {7'd0, ctx_ovf}, {7'd0, e.ovf});
    chk({tag, " ctx_unf"}, {7'd0, ctx_unf}, {7'd0, e.unf});
    chk({tag, " wr_drop"}, {7'd0, wr_drop}, {7'd0, e.drop});
`ifdef W_ZERO_FLAG_EN
    chk({tag, " w_zero"}, {7'd0, w_zero}, {7'd0, (e.w == 8'h00)});
`endif
  endtask

  task automatic setIdle();
    wr_stb = 1'b0; wr_op = NONE; dest_f = 1'b0; ctx_push = 1'b0; ctx_pop = 1'b0;
  endtask

  task automatic applyVec(vec_t v, int idx);
    exp_t e;
    wr_stb = v.stb; wr_op = v.op; dest_f = v.dest; alu_in = v.alu; gpr_in = v.gpr; lit_in = v.lit;
    ctx_push = v.push; ctx_pop = v.pop;
    e.w = v.eW; e.lvl = v.eLvl; e.ovf = v.eOvf; e.unf = v.eUnf; e.drop = v.eDrop;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      nCmp++; nFail++;
      $display("FAIL scoreboard: got empty queue, required an entry");
    end else begin
      checkNow($sformatf("vec%0d", idx), expQ.pop_front());
    end
  endtask

  initial begin
    exp_t rstExp;
    rstExp.w = 8'h00; rstExp.lvl = 3'd0; rstExp.ovf = 1'b0; rstExp.unf = 1'b0; rstExp.drop = 1'b0;

    //            stb op  d  alu    gpr    lit    pu po  eW     lvl ov un dr
    vecs.push_back(mk(1, LIT,  0, 8'hE1, 8'hE2, 8'h3C, 0, 0, 8'h3C, 0, 0, 0, 0));
    vecs.push_back(mk(1, ALUD, 1, 8'h11, 8'hE2, 8'hE3, 0, 0, 8'h3C, 0, 0, 0, 0));
    vecs.push_back(mk(1, ALUD, 0, 8'h11, 8'hE2, 8'hE3, 0, 0, 8'h11, 0, 0, 0, 0));
    vecs.push_back(mk(1, GPRD, 0, 8'hE1, 8'h7E, 8'hE3, 0, 0, 8'h7E, 0, 0, 0, 0));
    vecs.push_back(mk(1, GPRD, 1, 8'hE1, 8'h99, 8'hE3, 0, 0, 8'h7E, 0, 0, 0, 0));
    vecs.push_back(mk(1, CLR,  0, 8'hE1, 8'hE2, 8'hE3, 0, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3'd6, 0, 8'hE1, 8'hE2, 8'hE3, 0, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3'd7, 0, 8'hE1, 8'hE2, 8'hE3, 0, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(1, ALU,  1, 8'h5A, 8'hE2, 8'hE3, 0, 0, 8'h5A, 0, 0, 0, 0));
    vecs.push_back(mk(0, LIT,  0, 8'hE1, 8'hE2, 8'h77, 0, 0, 8'h5A, 0, 0, 0, 0));
    // fill past depth, then drain past empty
    vecs.push_back(mk(1, LIT,  0, 8'hE1, 8'hE2, 8'h01, 0, 0, 8'h01, 0, 0, 0, 0));
    vecs.push_back(mk(1, LIT,  0, 8'hE1, 8'hE2, 8'h02, 1, 0, 8'h02, 1, 0, 0, 0));
    vecs.push_back(mk(1, LIT,  0, 8'hE1, 8'hE2, 8'h03, 1, 0, 8'h03, 2, 0, 0, 0));
    vecs.push_back(mk(1, LIT,  0, 8'hE1, 8'hE2, 8'h04, 1, 0, 8'h04, 3, 0, 0, 0));
    vecs.push_back(mk(1, LIT,  0, 8'hE1, 8'hE2, 8'h05, 1, 0, 8'h05, 4, 0, 0, 0));
    vecs.push_back(mk(0, NONE, 0, 8'hE1, 8'hE2, 8'hE3, 1, 0, 8'h05, 4, 1, 0, 0));
    vecs.push_back(mk(0, NONE, 0, 8'hE1, 8'hE2, 8'hE3, 0, 1, 8'h05, 3, 1, 0, 0));
    vecs.push_back(mk(0, NONE, 0, 8'hE1, 8'hE2, 8'hE3, 0, 1, 8'h04, 2, 1, 0, 0));
    vecs.push_back(mk(0, NONE, 0, 8'hE1, 8'hE2, 8'hE3, 0, 1, 8'h03, 1, 1, 0, 0));
    vecs.push_back(mk(0, NONE, 0, 8'hE1, 8'hE2, 8'hE3, 0, 1, 8'h02, 0, 1, 0, 0));
    vecs.push_back(mk(0, NONE, 0, 8'hE1, 8'hE2, 8'hE3, 0, 1, 8'h02, 0, 1, 1, 0));
    // pop vs write collision
    vecs.push_back(mk(1, LIT,  0, 8'hE1, 8'hE2, 8'h55, 0, 0, 8'h55, 0, 1, 1, 0));
    vecs.push_back(mk(1, LIT,  0, 8'hE1, 8'hE2, 8'h10, 1, 0, 8'h10, 1, 1, 1, 0));
    vecs.push_back(mk(1, LIT,  0, 8'hE1, 8'hE2, 8'h99, 0, 1, 8'h55, 0, 1, 1, 1));
    vecs.push_back(mk(0, NONE, 0, 8'hE1, 8'hE2, 8'hE3, 0, 0, 8'h55, 0, 1, 1, 0));
    // push with write saves the pre-write W
    vecs.push_back(mk(1, LIT,  0, 8'hE1, 8'hE2, 8'h20, 0, 0, 8'h20, 0, 1, 1, 0));
    vecs.push_back(mk(1, LIT,  0, 8'hE1, 8'hE2, 8'h40, 1, 0, 8'h40, 1, 1, 1, 0));
    vecs.push_back(mk(0, NONE, 0, 8'hE1, 8'hE2, 8'hE3, 0, 1, 8'h20, 0, 1, 1, 0));
    // exchange, then exchange on empty (behaves as empty pop)
    vecs.push_back(mk(1, LIT,  0, 8'hE1, 8'hE2, 8'hAA, 0, 0, 8'hAA, 0, 1, 1, 0));
    vecs.push_back(mk(1, LIT,  0, 8'hE1, 8'hE2, 8'h0F, 1, 0, 8'h0F, 1, 1, 1, 0));
    vecs.push_back(mk(0, NONE, 0, 8'hE1, 8'hE2, 8'hE3, 1, 1, 8'hAA, 1, 1, 1, 0));
    vecs.push_back(mk(0, NONE, 0, 8'hE1, 8'hE2, 8'hE3, 0, 1, 8'h0F, 0, 1, 1, 0));
    vecs.push_back(mk(0, NONE, 0, 8'hE1, 8'hE2, 8'hE3, 1, 1, 8'h0F, 0, 1, 1, 0));
    vecs.push_back(mk(0, NONE, 0, 8'hE1, 8'hE2, 8'hE3, 0, 1, 8'h0F, 0, 1, 1, 0));
    // pop with a non-effective write pending: no drop
    vecs.push_back(mk(0, NONE, 0, 8'hE1, 8'hE2, 8'hE3, 1, 0, 8'h0F, 1, 1, 1, 0));
    vecs.push_back(mk(1, LIT,  0, 8'hE1, 8'hE2, 8'h33, 0, 0, 8'h33, 1, 1, 1, 0));
    vecs.push_back(mk(1, ALUD, 1, 8'h66, 8'hE2, 8'hE3, 0, 1, 8'h0F, 0, 1, 1, 0));
    vecs.push_back(mk(1, CLR,  0, 8'hE1, 8'hE2, 8'hE3, 0, 0, 8'h00, 0, 1, 1, 0));
    // build W=A5, level=2 for the mid-run reset
    vecs.push_back(mk(1, LIT,  0, 8'hE1, 8'hE2, 8'hA5, 1, 0, 8'hA5, 1, 1, 1, 0));
    vecs.push_back(mk(0, NONE, 0, 8'hE1, 8'hE2, 8'hE3, 1, 0, 8'hA5, 2, 1, 1, 0));

    #2 rst = 1'b1;
    #1 checkNow("reset_initial", rstExp);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyVec(vecs[i], i);
    end

    // asynchronous reset mid-cycle, checked before any clock edge
    setIdle();
    @(negedge clk);
    #1 rst = 1'b1;
    #1 checkNow("reset_async", rstExp);
    @(negedge clk);
    rst = 1'b0;
    applyVec(mk(0, NONE, 0, 8'hE1, 8'hE2, 8'hE3, 0, 1, 8'h00, 0, 0, 1, 0), 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
